// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, funct3
// access encodings, access-size decoding and the store byte-merge helper.
package lsu_pkg;

  // FSM state encoding, kept as plain constants so older tools and
  // waveform scripts that expect a 2-bit state vector keep working.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // funct3 encodings for the access size and signedness.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } access_size_t;

  // Reduce funct3 to an access size; the unused codes 011, 110 and 111
  // fall through to word accesses.
  function automatic access_size_t decode_size(input logic [2:0] funct3);
    access_size_t size;
    case (funct3)
      F3_LB, F3_LBU: size = SIZE_BYTE;
      F3_LH, F3_LHU: size = SIZE_HALF;
      default:       size = SIZE_WORD;
    endcase
    return size;
  endfunction

  // Replace only the addressed byte or half of an existing memory word with
  // the right-aligned store data; a word store replaces everything.
  function automatic logic [31:0] merge_store(input logic [31:0]  word,
                                              input logic [31:0]  data,
                                              input logic [1:0]   offset,
                                              input access_size_t size);
    logic [31:0] merged;
    merged = data;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0:    merged = {word[31:8], data[7:0]};
          2'd1:    merged = {word[31:16], data[7:0], word[7:0]};
          2'd2:    merged = {word[31:24], data[7:0], word[15:0]};
          default: merged = {data[7:0], word[23:0]};
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) merged = {data[15:0], word[15:0]};
        else           merged = {word[31:16], data[15:0]};
      end
      default: merged = data;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load lane selection: picks the addressed byte or half out of
// a memory word and sign- or zero-extends it according to funct3.
module load_extender
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  access_size_t size;
  logic         sign_extend;
  logic [7:0]   lane_byte;
  logic [15:0]  lane_half;

  // Select the lane by address offset and widen it to 32 bits.
  always_comb begin
    size        = decode_size(funct3);
    sign_extend = ~funct3[2];
    lane_half   = offset[1] ? word[31:16] : word[15:0];
    case (offset)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
    case (size)
      SIZE_BYTE: result = {{24{sign_extend & lane_byte[7]}}, lane_byte};
      SIZE_HALF: result = {{16{sign_extend & lane_half[15]}}, lane_half};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-wide RAM that reads
// combinationally and writes on the falling clock edge. Sub-word stores are
// done as read-modify-write. Optional misaligned-access trapping is enabled
// by defining LSU_MISALIGN_TRAP_EN; without it respError is tied low and the
// low address bits below the access size are ignored.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [31:0] memAddress,
  output logic [31:0] memDataIn,
  input  logic [31:0] memDataOut
);

  logic [1:0]   state;
  logic         lat_write;
  logic [2:0]   lat_funct3;
  logic [31:0]  lat_address;
  logic [31:0]  wr_word;
  logic [31:0]  resp_data_q;
  logic [31:0]  load_result;
  logic         misaligned;
  access_size_t req_size;
  access_size_t lat_size;

  assign req_size = decode_size(reqFunct3);
  assign lat_size = decode_size(lat_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic resp_error_q;

  assign misaligned = ((req_size == SIZE_HALF) && reqAddress[0]) ||
                      ((req_size == SIZE_WORD) && (reqAddress[1:0] != 2'b00));
  assign respError  = (state == ST_RESP) ? resp_error_q : 1'b0;

  // Remember whether the accepted request trapped, for the response cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_error_q <= 1'b0;
    end else if ((state == ST_IDLE) && reqValid) begin
      resp_error_q <= misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign respError  = 1'b0;
`endif

  // Lane select and extension of the word currently presented by the RAM.
  load_extender u_load_extender (
    .word   (memDataOut),
    .offset (lat_address[1:0]),
    .funct3 (lat_funct3),
    .result (load_result)
  );

  // Request/response FSM. SW goes straight to WRITE with the store data as
  // the write word; SB/SH first read the word so the merge can keep the
  // untouched lanes. Trapped accesses skip memory entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      lat_write   <= 1'b0;
      lat_funct3  <= 3'b000;
      lat_address <= 32'h0;
      wr_word     <= 32'h0;
      resp_data_q <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (reqValid) begin
            lat_write   <= reqWrite;
            lat_funct3  <= reqFunct3;
            lat_address <= reqAddress;
            wr_word     <= reqData;
            resp_data_q <= 32'h0;
            if (misaligned) begin
              state <= ST_RESP;
            end else if (reqWrite && (req_size == SIZE_WORD)) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (lat_write) begin
            wr_word <= merge_store(memDataOut, wr_word, lat_address[1:0], lat_size);
            state   <= ST_WRITE;
          end else begin
            resp_data_q <= load_result;
            state       <= ST_RESP;
          end
        end
        ST_WRITE: begin
          state <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from the state; the asynchronous reset already
  // forces IDLE, and reqReady is additionally masked while reset is high.
  // Because the write enable is a pure state decode, a reset during WRITE
  // drops it before the RAM's falling-edge write.
  always_comb begin
    reqReady       = (state == ST_IDLE) && !reset;
    memReadEnable  = (state == ST_READ);
    memWriteEnable = (state == ST_WRITE);
    memAddress     = 32'h0;
    memDataIn      = 32'h0;
    respValid      = (state == ST_RESP);
    respData       = 32'h0;
    if ((state == ST_READ) || (state == ST_WRITE)) begin
      memAddress = {lat_address[31:2], 2'b00};
    end
    if (state == ST_WRITE) begin
      memDataIn = wr_word;
    end
    if (state == ST_RESP) begin
      respData = resp_data_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word RAM model and a
// scoreboard of expected responses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddress;
  logic [31:0] reqData;
  logic        respValid;
  logic [31:0] respData;
  logic        respError;
  logic        memReadEnable;
  logic        memWriteEnable;
  logic [31:0] memAddress;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          rd_cycles   = 0;
  int          wr_cycles   = 0;
  int          resp_pulses = 0;
  int          both_on     = 0;

  logic [31:0] mem [0:63];
  logic        mem_clear;
  logic        mem_load;
  logic [5:0]  load_idx;
  logic [31:0] load_val;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqWrite       (reqWrite),
    .reqFunct3      (reqFunct3),
    .reqAddress     (reqAddress),
    .reqData        (reqData),
    .respValid      (respValid),
    .respData       (respData),
    .respError      (respError),
    .memReadEnable  (memReadEnable),
    .memWriteEnable (memWriteEnable),
    .memAddress     (memAddress),
    .memDataIn      (memDataIn),
    .memDataOut     (memDataOut)
  );

  // RAM model: combinational read, falling-edge write, plus bench preload.
  assign memDataOut = mem[memAddress[7:2]];

  always @(negedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_load) begin
      mem[load_idx] <= load_val;
    end else if (memWriteEnable) begin
      mem[memAddress[7:2]] <= memDataIn;
    end
  end

  // Activity counters sampled on the RAM's edge.
  always @(negedge clk) begin
    if (memReadEnable)                   rd_cycles   <= rd_cycles + 1;
    if (memWriteEnable)                  wr_cycles   <= wr_cycles + 1;
    if (respValid)                       resp_pulses <= resp_pulses + 1;
    if (memReadEnable && memWriteEnable) both_on     <= both_on + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for the response of the oldest scoreboard entry and compare it.
  task automatic check_output(input int rd0, input int wr0);
    exp_t e;
    int   n;
    bit   seen;
    e    = sb_q.pop_front();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (respValid === 1'b1) seen = 1'b1;
      else check({e.tag, "/ready_busy"}, 32'(reqReady), 32'd0);
    end
    check({e.tag, "/latency"}, 32'(n), 32'(e.lat));
    check({e.tag, "/data"}, respData, e.data);
    check({e.tag, "/error"}, 32'(respError), 32'(e.err));
    check({e.tag, "/ready_resp"}, 32'(reqReady), 32'd0);
    #1;
    check({e.tag, "/reads"}, 32'(rd_cycles - rd0), 32'(e.rd));
    check({e.tag, "/writes"}, 32'(wr_cycles - wr0), 32'(e.wr));
    @(negedge clk);
    check({e.tag, "/pulse_end"}, 32'(respValid), 32'd0);
    check({e.tag, "/ready_idle"}, 32'(reqReady), 32'd1);
  endtask

  // Drive one request, push its expected outcome, and follow it through.
  task automatic apply_stimulus(input string tag, input logic w, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] exp_data, input logic exp_err,
                                input int exp_lat, input int exp_rd, input int exp_wr,
                                input bit hold);
    exp_t e;
    int   guard;
    int   rd0;
    int   wr0;
    e.tag = tag; e.data = exp_data; e.err = exp_err;
    e.lat = exp_lat; e.rd = exp_rd; e.wr = exp_wr;
    sb_q.push_back(e);
    reqWrite   = w;
    reqFunct3  = f3;
    reqAddress = a;
    reqData    = d;
    reqValid   = 1'b1;
    guard      = 0;
    while (reqReady !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "/accept"}, 32'(reqReady), 32'd1);
    @(posedge clk);
    #1;
    rd0 = rd_cycles;
    wr0 = wr_cycles;
    if (!hold) reqValid = 1'b0;
    check_output(rd0, wr0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    reset      = 1'b1;
    reqValid   = 1'b0;
    reqWrite   = 1'b0;
    reqFunct3  = 3'b000;
    reqAddress = 32'h0;
    reqData    = 32'h0;
    mem_clear  = 1'b1;
    mem_load   = 1'b0;
    load_idx   = 6'd0;
    load_val   = 32'h0;
    @(negedge clk);
    mem_clear = 1'b0;
    mem_load  = 1'b1;
    load_idx  = 6'd4;
    load_val  = 32'h8899AABB;
    @(negedge clk);
    load_idx  = 6'd12;
    load_val  = 32'h12345678;
    @(negedge clk);
    mem_load  = 1'b0;

    $display("[TB] reset state");
    check("rst/reqReady", 32'(reqReady), 32'd0);
    check("rst/respValid", 32'(respValid), 32'd0);
    check("rst/respData", respData, 32'h0);
    check("rst/respError", 32'(respError), 32'd0);
    check("rst/enables", 32'({memReadEnable, memWriteEnable}), 32'd0);
    check("rst/memAddress", memAddress, 32'h0);
    check("rst/memDataIn", memDataIn, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] loads from preloaded word");
    apply_stimulus("LB13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1, 0, 1'b0);
    apply_stimulus("LHU10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 2, 1, 0, 1'b0);
    apply_stimulus("LH12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0, 1'b0);
    apply_stimulus("LBU12", 1'b0, 3'b100, 32'h12, 32'h0, 32'h00000099, 1'b0, 2, 1, 0, 1'b0);
    apply_stimulus("LB10",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 1, 0, 1'b0);

    $display("[TB] sub-word stores");
    apply_stimulus("SB11",  1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0, 1'b0, 3, 1, 1, 1'b0);
    apply_stimulus("LW10a", 1'b0, 3'b010, 32'h10, 32'h0, 32'h889955BB, 1'b0, 2, 1, 0, 1'b0);
    apply_stimulus("SH12",  1'b1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 3, 1, 1, 1'b0);
    apply_stimulus("LW10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h123455BB, 1'b0, 2, 1, 0, 1'b0);
    apply_stimulus("LH10",  1'b0, 3'b001, 32'h10, 32'h0, 32'h000055BB, 1'b0, 2, 1, 0, 1'b0);

    $display("[TB] word store and word-alias funct3");
    apply_stimulus("SW20",  1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 1'b0);
    apply_stimulus("LW20",  1'b0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b0);
    apply_stimulus("L011",  1'b0, 3'b011, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b0);
    apply_stimulus("L110",  1'b0, 3'b110, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b0);

    $display("[TB] back-to-back requests");
    apply_stimulus("B2B_LW",  1'b0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b1);
    apply_stimulus("B2B_LBU", 1'b0, 3'b100, 32'h21, 32'h0, 32'h000000BE, 1'b0, 2, 1, 0, 1'b0);

    $display("[TB] misaligned accesses");
`ifdef LSU_MISALIGN_TRAP_EN
    apply_stimulus("MIS_LW22", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
    apply_stimulus("MIS_LH21", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
    apply_stimulus("MIS_SH23", 1'b1, 3'b001, 32'h23, 32'h00000000, 32'h0, 1'b1, 1, 0, 0, 1'b0);
    apply_stimulus("MIS_CHK",  1'b0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b0);
`else
    apply_stimulus("MIS_LW22", 1'b0, 3'b010, 32'h22, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b0);
    apply_stimulus("MIS_LH21", 1'b0, 3'b001, 32'h21, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1, 0, 1'b0);
`endif

    $display("[TB] reset during WRITE");
    reqWrite   = 1'b1;
    reqFunct3  = 3'b010;
    reqAddress = 32'h30;
    reqData    = 32'hCAFEF00D;
    reqValid   = 1'b1;
    check("RST_WR/accept", 32'(reqReady), 32'd1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    p0       = resp_pulses;
    check("RST_WR/in_write", 32'(memWriteEnable), 32'd1);
    reset = 1'b1;
    #1;
    check("RST_WR/we_dropped", 32'(memWriteEnable), 32'd0);
    check("RST_WR/addr_zero", memAddress, 32'h0);
    check("RST_WR/ready_low", 32'(reqReady), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("RST_WR/no_resp", 32'(resp_pulses - p0), 32'd0);
    @(negedge clk);
    apply_stimulus("LW30", 1'b0, 3'b010, 32'h30, 32'h0, 32'h12345678, 1'b0, 2, 1, 0, 1'b0);

    check("never_both_enables", 32'(both_on), 32'd0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port reqValid, input, 1, CPU request present.
REQ-004 SHALL have port reqReady, output, 1, unit can accept a request.
REQ-005 SHALL have port reqWrite, input, 1, 1=store, 0=load.
REQ-006 SHALL have port reqFunct3, input, 3, access size and sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-007 SHALL have port reqAddress, input, 32, byte address.
REQ-008 SHALL have port reqData, input, 32, store data, right-aligned.
REQ-009 SHALL have port respValid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port respData, output, 32, extended load result; 0 for stores.
REQ-011 SHALL have port respError, output, 1, misaligned-access flag.
REQ-012 SHALL have ports memReadEnable, output, 1; memWriteEnable, output, 1; memAddress, output, 32; memDataIn, output, 32; memDataOut, input, 32; these drive the word-wide RAM, which reads combinationally and writes on negedge clk.

Function
REQ-013 SHALL implement states IDLE, READ, WRITE and RESP.
REQ-014 SHALL assert reqReady only in IDLE and SHALL accept a request on a posedge where reqValid and reqReady are both 1, latching write, funct3, address and data.
REQ-015 SHALL transition from IDLE to READ for loads, SB and SH, and from IDLE directly to WRITE for SW.
REQ-016 In READ, SHALL assert memReadEnable and SHALL capture memDataOut at the closing posedge; then SHALL go to RESP for a load or to WRITE for a store.
REQ-017 In WRITE, SHALL assert memWriteEnable for exactly one cycle, with memAddress and memDataIn stable for that whole cycle; then SHALL go to RESP.
REQ-018 SHALL drive memAddress = {address[31:2], 2'b00} in READ and WRITE, and 0 otherwise.
REQ-019 SHALL build SB/SH write data as a read-modify-write: only the addressed byte (address[1:0]) or half (address[1]) of the captured word is replaced with reqData[7:0] or reqData[15:0].
REQ-020 SHALL select the load lane by address[1:0]; funct3 000/001 SHALL sign-extend and 100/101 SHALL zero-extend.
REQ-021 In RESP, SHALL pulse respValid for one cycle and SHALL return to IDLE; there is no response backpressure.
REQ-022 SHALL produce latency from acceptance posedge to respValid-high of 2 cycles for loads and SW, and 3 cycles for SB/SH.
REQ-023 SHALL treat funct3 values 011, 110 and 111 as word accesses.
REQ-024 SHALL keep memReadEnable and memWriteEnable at 0 outside READ and WRITE respectively, and SHALL never assert both together.

Reset
REQ-025 While reset is high, SHALL force state IDLE; reqReady, respValid, respData, respError, both enables, memAddress and memDataIn SHALL be 0.
REQ-026 If reset is asserted mid-operation, the access SHALL be abandoned with no respValid; if asserted during WRITE before the negedge, the RAM write SHALL not occur.

Configuration
REQ-027 SHALL use macro LSU_MISALIGN_TRAP_EN. When it is defined, half accesses with address[0]=1 and word accesses with address[1:0]!=0 SHALL go IDLE->RESP with no memory enables, respError=1 and respData=0. When it is undefined, respError SHALL be tied to 0, word accesses SHALL ignore address[1:0], and half accesses SHALL ignore address[0].

Structure
REQ-028 SHALL place the state enum and the funct3 encoding constants in shared package lsu_pkg.
REQ-029 SHALL place lane select and extension in combinational sub-module load_extender.

Verification
REQ-030 Preload RAM word 0x10 with 0x8899AABB, then issue LB at 0x13: respValid 2 cycles after acceptance, respData=0xFFFFFF88.
REQ-031 Same word, LHU at 0x10: respData=0x0000AABB; LH at 0x12: respData=0xFFFF8899.
REQ-032 SB reqData=0x55 to 0x11, then LW at 0x10: respData=0x8899_55BB; write latency 3 cycles; exactly one memWriteEnable cycle.
REQ-033 SW 0xDEADBEEF to 0x20: no READ cycle, respValid 2 cycles after acceptance, then LW at 0x20 returns 0xDEADBEEF.
REQ-034 Back-to-back reqValid held high: reqReady low from acceptance until the cycle after respValid; second request accepted in the IDLE cycle following RESP.
REQ-035 With LSU_MISALIGN_TRAP_EN defined, LW at 0x22: respError=1, respData=0, no enables asserted. Separately, asserting reset during WRITE of SW to 0x30 leaves RAM 0x30 unchanged and produces no respValid.
